imm_gen_pipe: RTL and testbench

- Multi-lane, pipelined immediate generator for the decode stage; generalises the single-instruction combinational immediate generator.
- Extracts and sign-extends immediates for LANES instructions per beat.
- Adds U-type support (LUI/AUIPC) and a per-lane format tag.
- Registered output behind a valid/ready handshake with a 2-entry skid buffer, so decode backpressure never drops an instruction.

---
 rtl/imm_gen_pipe.sv | 164 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: multi-lane pipelined immediate generator for decode.
// Each beat carries LANES instruction words. Every lane's immediate is
// extracted, sign-extended to XLEN and tagged with a format code. The result
// sits in a registered output stage behind a valid/ready handshake. A second
// (skid) register catches a beat that arrives while the output is stalled, so
// no instruction is ever dropped.
// Optional feature: define IMM_GEN_ERR_EN to add the err_count port, which
// counts valid lanes whose opcode is not recognised and not an R-type/system
// instruction.
module imm_gen_pipe #(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*32-1:0]     in_inst,
  input  logic [LANES-1:0]        in_lane_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*XLEN-1:0]   out_imm,
  output logic [LANES*3-1:0]      out_fmt,
  output logic [LANES-1:0]        out_lane_mask
`ifdef IMM_GEN_ERR_EN
  ,
  output logic [15:0]             err_count
`endif
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } fmt_e;

  // Opcode to format mapping; anything unrecognised is FMT_NONE.
  function automatic fmt_e fmt_of(input logic [31:0] inst);
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: fmt_of = FMT_I;
      7'b0100011:                         fmt_of = FMT_S;
      7'b1100011:                         fmt_of = FMT_B;
      7'b0110111, 7'b0010111:             fmt_of = FMT_U;
      7'b1101111:                         fmt_of = FMT_J;
      default:                            fmt_of = FMT_NONE;
    endcase
  endfunction

  // 32-bit sign-extended immediate; widening to XLEN happens at the call site.
  function automatic logic [31:0] imm32_of(input logic [31:0] inst);
    case (fmt_of(inst))
      FMT_I:   imm32_of = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm32_of = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm32_of = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                           inst[11:8], 1'b0};
      FMT_U:   imm32_of = {inst[31:12], 12'b0};
      FMT_J:   imm32_of = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                           inst[30:21], 1'b0};
      default: imm32_of = 32'b0;
    endcase
  endfunction

  logic [LANES*XLEN-1:0] dec_imm;
  logic [LANES*3-1:0]    dec_fmt;

  logic                  skid_valid;
  logic [LANES*XLEN-1:0] skid_imm;
  logic [LANES*3-1:0]    skid_fmt;
  logic [LANES-1:0]      skid_lane_mask;

  logic in_fire;
  logic out_free;

  // The skid register is the only thing that can refuse a beat, so readiness
  // follows its occupancy flop directly.
  assign in_ready = ~skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;

  // Decode every lane of the incoming beat; masked-off lanes yield zeros.
  always_comb begin
    dec_imm = '0;
    dec_fmt = '0;
    for (int k = 0; k < LANES; k++) begin
      if (in_lane_mask[k]) begin
        dec_fmt[3*k +: 3]       = fmt_of(in_inst[32*k +: 32]);
        dec_imm[XLEN*k +: XLEN] = XLEN'($signed(imm32_of(in_inst[32*k +: 32])));
      end
    end
  end

  // Output and skid registers: the skid always drains into the output before
  // any newer beat, which keeps beats in arrival order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid      <= 1'b0;
      out_imm        <= '0;
      out_fmt        <= '0;
      out_lane_mask  <= '0;
      skid_valid     <= 1'b0;
      skid_imm       <= '0;
      skid_fmt       <= '0;
      skid_lane_mask <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid     <= 1'b1;
        out_imm       <= skid_imm;
        out_fmt       <= skid_fmt;
        out_lane_mask <= skid_lane_mask;
        skid_valid    <= in_fire;
        if (in_fire) begin
          skid_imm       <= dec_imm;
          skid_fmt       <= dec_fmt;
          skid_lane_mask <= in_lane_mask;
        end
      end else if (in_fire) begin
        out_valid     <= 1'b1;
        out_imm       <= dec_imm;
        out_fmt       <= dec_fmt;
        out_lane_mask <= in_lane_mask;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_valid     <= 1'b1;
      skid_imm       <= dec_imm;
      skid_fmt       <= dec_fmt;
      skid_lane_mask <= in_lane_mask;
    end
  end

`ifdef IMM_GEN_ERR_EN
  logic [2:0]  err_inc;
  logic [16:0] err_sum;

  // Count valid lanes with an unknown opcode, excluding R-type and system ops.
  always_comb begin
    err_inc = '0;
    for (int k = 0; k < LANES; k++) begin
      if (in_lane_mask[k] &&
          (fmt_of(in_inst[32*k +: 32]) == FMT_NONE) &&
          (in_inst[32*k +: 7] != 7'b0110011) &&
          (in_inst[32*k +: 7] != 7'b1110011)) begin
        err_inc = err_inc + 3'd1;
      end
    end
  end

  assign err_sum = {1'b0, err_count} + {14'b0, err_inc};

  // Saturating error counter, advanced only on an accepted input beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (in_fire) begin
      err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed self-checking bench for imm_gen_pipe.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A second instance with XLEN=64 shares every input for the wide-sign check.
module tb_imm_gen_pipe;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_inst = '0;
  logic [1:0]   in_lane_mask = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_imm;
  logic [5:0]   out_fmt;
  logic [1:0]   out_lane_mask;

  logic         in_ready_w;
  logic         out_valid_w;
  logic [127:0] out_imm_w;
  logic [5:0]   out_fmt_w;
  logic [1:0]   out_lane_mask_w;

`ifdef IMM_GEN_ERR_EN
  logic [15:0]  err_count;
  logic [15:0]  err_count_w;
`endif

  int checks = 0;
  int errors = 0;

  imm_gen_pipe #(.LANES(2), .XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_lane_mask(in_lane_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_lane_mask(out_lane_mask)
`ifdef IMM_GEN_ERR_EN
    , .err_count(err_count)
`endif
  );

  imm_gen_pipe #(.LANES(2), .XLEN(64)) dut_w (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .in_inst(in_inst), .in_lane_mask(in_lane_mask),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_imm(out_imm_w), .out_fmt(out_fmt_w), .out_lane_mask(out_lane_mask_w)
`ifdef IMM_GEN_ERR_EN
    , .err_count(err_count_w)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Hard stop in case anything stalls the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] i0,
                               input logic [31:0] i1, input logic [1:0] m);
    in_valid     = v;
    in_inst      = {i1, i0};
    in_lane_mask = m;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_imm !== 64'h0) begin errors++; $display("[TB] FAIL reset_out_imm: got %h expected 0", out_imm); end
    checks++; if (out_fmt !== 6'h0) begin errors++; $display("[TB] FAIL reset_out_fmt: got %h expected 0", out_fmt); end
    checks++; if (out_lane_mask !== 2'b00) begin errors++; $display("[TB] FAIL reset_lane_mask: got %b expected 00", out_lane_mask); end
`ifdef IMM_GEN_ERR_EN
    checks++; if (err_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_err_count: got %h expected 0", err_count); end
`endif
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'hFFF00093, 32'h12345037, 2'b11);
    step;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); end
    checks++; if (out_imm[31:0] !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL basic_imm0: got %h expected ffffffff", out_imm[31:0]); end
    checks++; if (out_fmt[2:0] !== 3'd1) begin errors++; $display("[TB] FAIL basic_fmt0: got %0d expected 1", out_fmt[2:0]); end
    checks++; if (out_imm[63:32] !== 32'h12345000) begin errors++; $display("[TB] FAIL basic_imm1: got %h expected 12345000", out_imm[63:32]); end
    checks++; if (out_fmt[5:3] !== 3'd4) begin errors++; $display("[TB] FAIL basic_fmt1: got %0d expected 4", out_fmt[5:3]); end
    checks++; if (out_lane_mask !== 2'b11) begin errors++; $display("[TB] FAIL basic_mask: got %b expected 11", out_lane_mask); end
    step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_branch_jump;
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'hFE000EE3, 32'h0000006F, 2'b11);
    step;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checks++; if (out_imm[31:0] !== 32'hFFFFFFFC) begin errors++; $display("[TB] FAIL bj_imm0: got %h expected fffffffc", out_imm[31:0]); end
    checks++; if (out_fmt[2:0] !== 3'd3) begin errors++; $display("[TB] FAIL bj_fmt0: got %0d expected 3", out_fmt[2:0]); end
    checks++; if (out_imm[63:32] !== 32'h0) begin errors++; $display("[TB] FAIL bj_imm1: got %h expected 0", out_imm[63:32]); end
    checks++; if (out_fmt[5:3] !== 3'd5) begin errors++; $display("[TB] FAIL bj_fmt1: got %0d expected 5", out_fmt[5:3]); end
    step;
  endtask

  // Five beats on consecutive cycles: covers every format and the 1/cycle rate.
  task automatic test_back_to_back;
    logic [31:0] i0 [5] = '{32'hFE512C23, 32'hFFFFF097, 32'h001000EF, 32'hFFC08067, 32'h8000006F};
    logic [31:0] i1 [5] = '{32'h7FF00003, 32'h00000863, 32'h00000033, 32'h80000063, 32'h00000FA3};
    logic [31:0] e0 [5] = '{32'hFFFFFFF8, 32'hFFFFF000, 32'h00000800, 32'hFFFFFFFC, 32'hFFF00000};
    logic [31:0] e1 [5] = '{32'h000007FF, 32'h00000010, 32'h00000000, 32'hFFFFF000, 32'h0000001F};
    logic [2:0]  f0 [5] = '{3'd2, 3'd4, 3'd5, 3'd1, 3'd5};
    logic [2:0]  f1 [5] = '{3'd1, 3'd3, 3'd0, 3'd3, 3'd2};
    out_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      applyStimulus(1'b1, i0[b], i1[b], 2'b11);
      step;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_flow%0d: got valid=%b ready=%b expected 1 1", b, out_valid, in_ready); end
      checks++; if (out_imm[31:0] !== e0[b] || out_fmt[2:0] !== f0[b]) begin errors++; $display("[TB] FAIL b2b_lane0_%0d: got %h/%0d expected %h/%0d", b, out_imm[31:0], out_fmt[2:0], e0[b], f0[b]); end
      checks++; if (out_imm[63:32] !== e1[b] || out_fmt[5:3] !== f1[b]) begin errors++; $display("[TB] FAIL b2b_lane1_%0d: got %h/%0d expected %h/%0d", b, out_imm[63:32], out_fmt[5:3], e1[b], f1[b]); end
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    step;
  endtask

  task automatic test_lane_mask;
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'hFFF00093, 32'h00000013, 2'b01);
    step;
    checks++; if (out_imm[63:32] !== 32'h0 || out_fmt[5:3] !== 3'd0) begin errors++; $display("[TB] FAIL mask01_lane1: got %h/%0d expected 0/0", out_imm[63:32], out_fmt[5:3]); end
    checks++; if (out_imm[31:0] !== 32'hFFFFFFFF || out_fmt[2:0] !== 3'd1) begin errors++; $display("[TB] FAIL mask01_lane0: got %h/%0d expected ffffffff/1", out_imm[31:0], out_fmt[2:0]); end
    checks++; if (out_lane_mask !== 2'b01) begin errors++; $display("[TB] FAIL mask01_mask: got %b expected 01", out_lane_mask); end
    applyStimulus(1'b1, 32'h12345037, 32'hFFF00093, 2'b10);
    step;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checks++; if (out_imm[31:0] !== 32'h0 || out_fmt[2:0] !== 3'd0) begin errors++; $display("[TB] FAIL mask10_lane0: got %h/%0d expected 0/0", out_imm[31:0], out_fmt[2:0]); end
    checks++; if (out_imm[63:32] !== 32'hFFFFFFFF || out_lane_mask !== 2'b10) begin errors++; $display("[TB] FAIL mask10_lane1: got %h/%b expected ffffffff/10", out_imm[63:32], out_lane_mask); end
    step;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hFFF00093, 32'h12345037, 2'b11);
    step;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_c1: got valid=%b ready=%b expected 1 1", out_valid, in_ready); end
    applyStimulus(1'b1, 32'hFE000EE3, 32'h0000006F, 2'b11);
    step;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_c2_ready: got %b expected 0", in_ready); end
    applyStimulus(1'b1, 32'hFE512C23, 32'h7FF00003, 2'b11);
    step;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_c3_ready: got %b expected 0", in_ready); end
    checks++; if (out_imm[31:0] !== 32'hFFFFFFFF || out_fmt[5:3] !== 3'd4) begin errors++; $display("[TB] FAIL bp_hold: got %h/%0d expected ffffffff/4", out_imm[31:0], out_fmt[5:3]); end
    out_ready = 1'b1;
    step;
    checks++; if (out_valid !== 1'b1 || out_imm[31:0] !== 32'hFFFFFFFC || out_fmt[5:3] !== 3'd5) begin errors++; $display("[TB] FAIL bp_beat2: got %b/%h/%0d expected 1/fffffffc/5", out_valid, out_imm[31:0], out_fmt[5:3]); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_back: got %b expected 1", in_ready); end
    step;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checks++; if (out_valid !== 1'b1 || out_imm[31:0] !== 32'hFFFFFFF8 || out_fmt[5:3] !== 3'd1) begin errors++; $display("[TB] FAIL bp_beat3: got %b/%h/%0d expected 1/fffffff8/1", out_valid, out_imm[31:0], out_fmt[5:3]); end
    step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup: got %b expected 0", out_valid); end
  endtask

  task automatic test_xlen64;
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h80000537, 32'hFFF00093, 2'b11);
    step;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checks++; if (out_imm_w[63:0] !== 64'hFFFFFFFF80000000) begin errors++; $display("[TB] FAIL x64_imm0: got %h expected ffffffff80000000", out_imm_w[63:0]); end
    checks++; if (out_imm_w[127:64] !== 64'hFFFFFFFFFFFFFFFF || out_fmt_w !== 6'o14) begin errors++; $display("[TB] FAIL x64_lane1: got %h/%o expected ffffffffffffffff/14", out_imm_w[127:64], out_fmt_w); end
    checks++; if (out_imm[31:0] !== 32'h80000000) begin errors++; $display("[TB] FAIL x32_imm0: got %h expected 80000000", out_imm[31:0]); end
    step;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'hFFF00093, 32'h12345037, 2'b11);
    step;
    step;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ar_full: got valid=%b ready=%b expected 1 0", out_valid, in_ready); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ar_immediate: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
    checks++; if (out_lane_mask !== 2'b00 || out_valid_w !== 1'b0 || in_ready_w !== 1'b1) begin errors++; $display("[TB] FAIL ar_clear: got mask=%b wvalid=%b wready=%b expected 00 0 1", out_lane_mask, out_valid_w, in_ready_w); end
    @(negedge clk);
    reset_n = 1'b1;
    out_ready = 1'b1;
    step;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ar_discard: got %b expected 0", out_valid); end
  endtask

`ifdef IMM_GEN_ERR_EN
  task automatic test_err_count;
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h0000007F, 32'h0000007F, 2'b11);
    step;
    checks++; if (err_count !== 16'd2) begin errors++; $display("[TB] FAIL err_two: got %0d expected 2", err_count); end
    applyStimulus(1'b1, 32'h0000007F, 32'h0000007F, 2'b01);
    step;
    checks++; if (err_count !== 16'd3) begin errors++; $display("[TB] FAIL err_masked: got %0d expected 3", err_count); end
    applyStimulus(1'b1, 32'h00000033, 32'h00000073, 2'b11);
    step;
    applyStimulus(1'b0, 32'h0, 32'h0, 2'b00);
    checks++; if (err_count !== 16'd3) begin errors++; $display("[TB] FAIL err_excluded: got %0d expected 3", err_count); end
    step;
  endtask
`endif

  // Run every scenario in order, then report.
  initial begin
    test_reset;
`ifdef IMM_GEN_ERR_EN
    test_err_count;
`endif
    test_basic;
    test_branch_jump;
    test_back_to_back;
    test_lane_mask;
    test_backpressure;
    test_xlen64;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
